// File: rtl/bcd_countdown_timer.sv
// Mixed-radix BCD timer/stopwatch: digit-by-digit editing from button pulses,
// prescaled count down (timer) or up (stopwatch), with pause and optional auto-reload.

module bcd_countdown_timer_chk #(
  parameter int                  DIGITS  = 8,
  parameter logic [4*DIGITS-1:0] MAX_VEC = 32'h9959_5999,
  parameter int                  EDIT_LO = 2
) (
  input logic                        clk,
  input logic                        rst,
  input logic [4*DIGITS-1:0]         count_o,
  input logic [$clog2(DIGITS)-1:0]   cursor_o,
  input logic                        edit_o,
  input logic                        run_o
);

  a_mode_excl: assert property (@(posedge clk) disable iff (rst) !(edit_o && run_o));

  a_cursor_range: assert property (@(posedge clk) disable iff (rst)
    (int'(cursor_o) >= EDIT_LO) && (int'(cursor_o) <= DIGITS - 1));

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit_chk
    a_digit_max: assert property (@(posedge clk) disable iff (rst)
      count_o[4*g +: 4] <= MAX_VEC[4*g +: 4]);
  end

endmodule

module bcd_countdown_timer #(
  parameter int                  DIGITS      = 8,
  parameter logic [4*DIGITS-1:0] MAX_VEC     = 32'h9959_5999,
  parameter int                  TICK_DIV    = 100000,
  parameter int                  EDIT_LO     = 2,
  parameter bit                  AUTO_RELOAD = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      btn_u,
  input  logic                      btn_c,
  input  logic                      btn_d,
  input  logic                      btn_l,
  input  logic                      btn_r,
  input  logic                      mode_up,
  output logic [4*DIGITS-1:0]       count_o,
  output logic [$clog2(DIGITS)-1:0] cursor_o,
  output logic                      edit_o,
  output logic                      run_o,
  output logic                      done_o
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [CW-1:0] CUR_TOP   = CW'(DIGITS - 1);
  localparam logic [CW-1:0] CUR_LO    = CW'(EDIT_LO);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] PRE_ZERO  = {PW{1'b0}};
  localparam logic [PW-1:0] PRE_ONE   = PW'(1);
  localparam logic [W-1:0]  ZERO      = {W{1'b0}};

  typedef enum logic [1:0] {
    S_EDIT  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         state_r, state_s;
  logic [W-1:0]   count_r, count_s;
  logic [CW-1:0]  cursor_r, cursor_s;
  logic [PW-1:0]  presc_r, presc_s;
  logic [W-1:0]   reload_r, reload_s;
  logic           mode_r, mode_s;
  logic           pulse_s;
  logic           tick_s;
  logic [W-1:0]   stepped_s;
  logic           edit_r, run_r, done_r;

  // Down step: a zero digit becomes its max and the borrow ripples on.
  function automatic logic [W-1:0] step_down(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!borrow) begin
        r[4*i +: 4] = v[4*i +: 4];
      end else if (v[4*i +: 4] == 4'd0) begin
        r[4*i +: 4] = MAX_VEC[4*i +: 4];
      end else begin
        r[4*i +: 4] = v[4*i +: 4] - 4'd1;
        borrow      = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] step_up(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic         carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!carry) begin
        r[4*i +: 4] = v[4*i +: 4];
      end else if (v[4*i +: 4] >= MAX_VEC[4*i +: 4]) begin
        r[4*i +: 4] = 4'd0;
      end else begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd1;
        carry       = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] clear_low(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (i < EDIT_LO) begin
        r[4*i +: 4] = 4'd0;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  function automatic logic [W-1:0] digit_inc(input logic [W-1:0] v, input logic [CW-1:0] cur);
    logic [W-1:0] r;
    logic [3:0]   d, mx;
    int           base;
    base = 4 * int'(cur);
    r    = v;
    d    = v[base +: 4];
    mx   = MAX_VEC[base +: 4];
    r[base +: 4] = (d >= mx) ? 4'd0 : d + 4'd1;
    return r;
  endfunction

  function automatic logic [W-1:0] digit_dec(input logic [W-1:0] v, input logic [CW-1:0] cur);
    logic [W-1:0] r;
    logic [3:0]   d, mx;
    int           base;
    base = 4 * int'(cur);
    r    = v;
    d    = v[base +: 4];
    mx   = MAX_VEC[base +: 4];
    r[base +: 4] = (d == 4'd0) ? mx : d - 4'd1;
    return r;
  endfunction

  // Terminal is all-zero when counting down, all-max when counting up.
  function automatic logic is_terminal(input logic [W-1:0] v, input logic up);
    return up ? (v == MAX_VEC) : (v == ZERO);
  endfunction

  // Datapath helpers for the RUN state.
  always_comb begin
    tick_s    = (presc_r == TICK_LAST);
    stepped_s = mode_r ? step_up(count_r) : step_down(count_r);
  end

  // Next-state and next-value logic; button priority is u > l > r > c > d.
  always_comb begin
    state_s  = state_r;
    count_s  = count_r;
    cursor_s = cursor_r;
    presc_s  = presc_r;
    reload_s = reload_r;
    mode_s   = mode_r;
    pulse_s  = 1'b0;
    case (state_r)
      S_EDIT: begin
        if (btn_u) begin
          mode_s   = mode_up;
          reload_s = count_r;
          presc_s  = PRE_ZERO;
          state_s  = is_terminal(count_r, mode_up) ? S_DONE : S_RUN;
        end else if (btn_l) begin
          cursor_s = (cursor_r == CUR_TOP) ? CUR_LO : cursor_r + CW'(1);
        end else if (btn_r) begin
          cursor_s = (cursor_r == CUR_LO) ? CUR_TOP : cursor_r - CW'(1);
        end else if (btn_c) begin
          count_s = digit_inc(count_r, cursor_r);
        end else if (btn_d) begin
          count_s = digit_dec(count_r, cursor_r);
        end else begin
          state_s = S_EDIT;
        end
      end
      S_RUN: begin
        if (btn_u) begin
          state_s = S_PAUSE;
        end else if (btn_l) begin
          state_s  = S_EDIT;
          cursor_s = CUR_TOP;
          count_s  = clear_low(count_r);
        end else if (btn_d) begin
          state_s  = S_EDIT;
          cursor_s = CUR_TOP;
          count_s  = ZERO;
        end else if (tick_s) begin
          presc_s = PRE_ZERO;
          if (is_terminal(stepped_s, mode_r)) begin
            if (AUTO_RELOAD && !mode_r) begin
              count_s = reload_r;
              pulse_s = 1'b1;
            end else begin
              count_s = stepped_s;
              state_s = S_DONE;
            end
          end else begin
            count_s = stepped_s;
          end
        end else begin
          presc_s = presc_r + PRE_ONE;
        end
      end
      S_PAUSE: begin
        if (btn_u) begin
          state_s = S_RUN;
        end else if (btn_l) begin
          state_s  = S_EDIT;
          cursor_s = CUR_TOP;
          count_s  = clear_low(count_r);
        end else if (btn_d) begin
          state_s  = S_EDIT;
          cursor_s = CUR_TOP;
          count_s  = ZERO;
        end else begin
          state_s = S_PAUSE;
        end
      end
      S_DONE: begin
        if (btn_u || btn_l) begin
          state_s  = S_EDIT;
          cursor_s = CUR_TOP;
          count_s  = clear_low(count_r);
        end else if (btn_d) begin
          state_s  = S_EDIT;
          cursor_s = CUR_TOP;
          count_s  = ZERO;
        end else begin
          state_s = S_DONE;
        end
      end
      default: begin
        state_s  = S_EDIT;
        cursor_s = CUR_TOP;
        count_s  = ZERO;
        presc_s  = PRE_ZERO;
      end
    endcase
  end

  // State, datapath and registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= S_EDIT;
      count_r  <= ZERO;
      cursor_r <= CUR_TOP;
      presc_r  <= PRE_ZERO;
      reload_r <= ZERO;
      mode_r   <= 1'b0;
      edit_r   <= 1'b1;
      run_r    <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      count_r  <= count_s;
      cursor_r <= cursor_s;
      presc_r  <= presc_s;
      reload_r <= reload_s;
      mode_r   <= mode_s;
      edit_r   <= (state_s == S_EDIT);
      run_r    <= (state_s == S_RUN);
      done_r   <= (state_s == S_DONE) || pulse_s;
    end
  end

  assign count_o  = count_r;
  assign cursor_o = cursor_r;
  assign edit_o   = edit_r;
  assign run_o    = run_r;
  assign done_o   = done_r;

  bcd_countdown_timer_chk #(
    .DIGITS  (DIGITS),
    .MAX_VEC (MAX_VEC),
    .EDIT_LO (EDIT_LO)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .count_o  (count_r),
    .cursor_o (cursor_r),
    .edit_o   (edit_r),
    .run_o    (run_r)
  );

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: two configurations share one button stream and are
// compared every cycle with an integer-valued reference model, plus directed checkpoints.

module tb_bcd_countdown_timer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_u = 1'b0, btn_c = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0;
  logic mode_up = 1'b0;

  logic [15:0] cnt0, cnt1;
  logic [1:0]  cur0, cur1;
  logic        edit0, edit1, run0, run1, done0, done1;

  int passed = 0;
  int total  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  bcd_countdown_timer #(
    .DIGITS(4), .MAX_VEC(16'h5959), .TICK_DIV(2), .EDIT_LO(0), .AUTO_RELOAD(1'b0)
  ) dut0 (
    .clk(clk), .rst(rst), .btn_u(btn_u), .btn_c(btn_c), .btn_d(btn_d),
    .btn_l(btn_l), .btn_r(btn_r), .mode_up(mode_up),
    .count_o(cnt0), .cursor_o(cur0), .edit_o(edit0), .run_o(run0), .done_o(done0)
  );

  bcd_countdown_timer #(
    .DIGITS(4), .MAX_VEC(16'h5959), .TICK_DIV(1), .EDIT_LO(1), .AUTO_RELOAD(1'b1)
  ) dut1 (
    .clk(clk), .rst(rst), .btn_u(btn_u), .btn_c(btn_c), .btn_d(btn_d),
    .btn_l(btn_l), .btn_r(btn_r), .mode_up(mode_up),
    .count_o(cnt1), .cursor_o(cur1), .edit_o(edit1), .run_o(run1), .done_o(done1)
  );

  // Reference model: the count is a plain integer in a mixed-radix number system.
  int rad [4] = '{10, 6, 10, 6};
  int wgt [4] = '{1, 10, 60, 600};
  int maxn = 3599;
  int tdiv [2] = '{2, 1};
  int elo  [2] = '{0, 1};
  bit ar   [2] = '{1'b0, 1'b1};

  localparam int ME = 0, MR = 1, MP = 2, MD = 3;
  int m_st [2], m_n [2], m_cur [2], m_pre [2], m_rel [2];
  bit m_md [2], m_pls [2];
  bit mu_v = 1'b0;

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    int d;
    r = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      d = (n / wgt[i]) % rad[i];
      r[4*i +: 4] = d[3:0];
    end
    return r;
  endfunction

  function automatic bit term(input int n, input bit up);
    return up ? (n == maxn) : (n == 0);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = ME; m_n[k] = 0; m_cur[k] = 3; m_pre[k] = 0;
      m_rel[k] = 0; m_md[k] = 1'b0; m_pls[k] = 1'b0;
    end
  endtask

  task automatic enter_edit(input int k, input bit zero);
    m_st[k]  = ME;
    m_cur[k] = 3;
    if (zero) m_n[k] = 0;
    else      m_n[k] = m_n[k] - (m_n[k] % wgt[elo[k]]);
  endtask

  task automatic model_step(input int k, input bit u, input bit c, input bit d,
                            input bit l, input bit r, input bit mu);
    int dg, nd, n2, rd;
    m_pls[k] = 1'b0;
    case (m_st[k])
      ME: begin
        if (u) begin
          m_md[k] = mu; m_rel[k] = m_n[k]; m_pre[k] = 0;
          m_st[k] = term(m_n[k], mu) ? MD : MR;
        end else if (l) m_cur[k] = (m_cur[k] == 3) ? elo[k] : m_cur[k] + 1;
        else if (r)     m_cur[k] = (m_cur[k] == elo[k]) ? 3 : m_cur[k] - 1;
        else if (c || d) begin
          rd = rad[m_cur[k]];
          dg = (m_n[k] / wgt[m_cur[k]]) % rd;
          nd = c ? (dg + 1) % rd : (dg + rd - 1) % rd;
          m_n[k] = m_n[k] + (nd - dg) * wgt[m_cur[k]];
        end
      end
      MR: begin
        if (u) m_st[k] = MP;
        else if (l) enter_edit(k, 1'b0);
        else if (d) enter_edit(k, 1'b1);
        else if (m_pre[k] == tdiv[k] - 1) begin
          m_pre[k] = 0;
          n2 = m_md[k] ? m_n[k] + 1 : m_n[k] - 1;
          if (term(n2, m_md[k])) begin
            if (ar[k] && !m_md[k]) begin m_n[k] = m_rel[k]; m_pls[k] = 1'b1; end
            else begin m_n[k] = n2; m_st[k] = MD; end
          end else m_n[k] = n2;
        end else m_pre[k] = m_pre[k] + 1;
      end
      MP: begin
        if (u) m_st[k] = MR;
        else if (l) enter_edit(k, 1'b0);
        else if (d) enter_edit(k, 1'b1);
      end
      MD: begin
        if (u || l) enter_edit(k, 1'b0);
        else if (d) enter_edit(k, 1'b1);
      end
      default: ;
    endcase
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ph);
    chk({ph, "_cnt0"},  cnt0,        to_bcd(m_n[0]));
    chk({ph, "_cur0"},  16'(cur0),   16'(m_cur[0]));
    chk({ph, "_edit0"}, 16'(edit0),  16'(m_st[0] == ME));
    chk({ph, "_run0"},  16'(run0),   16'(m_st[0] == MR));
    chk({ph, "_done0"}, 16'(done0),  16'(m_st[0] == MD || m_pls[0]));
    chk({ph, "_cnt1"},  cnt1,        to_bcd(m_n[1]));
    chk({ph, "_cur1"},  16'(cur1),   16'(m_cur[1]));
    chk({ph, "_edit1"}, 16'(edit1),  16'(m_st[1] == ME));
    chk({ph, "_run1"},  16'(run1),   16'(m_st[1] == MR));
    chk({ph, "_done1"}, 16'(done1),  16'(m_st[1] == MD || m_pls[1]));
  endtask

  task automatic cycle(input bit u, input bit c, input bit d, input bit l, input bit r);
    btn_u = u; btn_c = c; btn_d = d; btn_l = l; btn_r = r; mode_up = mu_v;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) model_step(k, u, c, d, l, r, mu_v);
    btn_u = 1'b0; btn_c = 1'b0; btn_d = 1'b0; btn_l = 1'b0; btn_r = 1'b0;
    check_all("cyc");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Asynchronous reset applied between clock edges; outputs must clear at once.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    chk("rst_cnt0",  cnt0,       16'h0000);
    chk("rst_edit0", 16'(edit0), 16'd1);
    chk("rst_run0",  16'(run0),  16'd0);
    chk("rst_done0", 16'(done0), 16'd0);
    chk("rst_cur0",  16'(cur0),  16'd3);
    check_all("rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int j, en, pr;
    logic [15:0] held;
    model_reset();
    #12;
    check_all("por");
    rst = 1'b0;

    // Digit editing with wrap.
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t1_2000", cnt0, 16'h2000);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t1_2900", cnt0, 16'h2900);

    // Countdown from 0100 to DONE.
    do_reset();
    mu_v = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t2_load", cnt0, 16'h0100);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t2_run", 16'(run0), 16'd1);
    idle(2);
    chk("t2_0059", cnt0, 16'h0059);
    idle(2);
    chk("t2_0058", cnt0, 16'h0058);
    j = 0;
    while (!done0 && j < 200) begin idle(1); j++; end
    chk("t2_done", 16'(done0), 16'd1);
    chk("t2_zero", cnt0, 16'h0000);
    chk("t2_stop", 16'(run0), 16'd0);

    // Stopwatch to terminal 5959.
    do_reset();
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("t3_load", cnt0, 16'h5957);
    mu_v = 1'b1;
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("t3_5958", cnt0, 16'h5958);
    idle(2);
    chk("t3_5959", cnt0, 16'h5959);
    chk("t3_done", 16'(done0), 16'd1);
    idle(3);
    chk("t3_hold", cnt0, 16'h5959);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t3_edit", 16'(edit0), 16'd1);
    chk("t3_ndone", 16'(done0), 16'd0);
    chk("t3_kept", cnt0, 16'h5959);

    // Pause holds the count and the prescaler phase.
    do_reset();
    mu_v = 1'b0;
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4_load", cnt0, 16'h0030);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    held = cnt0;
    chk("t4_paused", held, 16'h0029);
    for (int i = 0; i < 10; i++) begin
      idle(1);
      chk("t4_hold", cnt0, 16'h0029);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t4_resume", cnt0, 16'h0029);
    idle(1);
    chk("t4_step", cnt0, 16'h0028);

    // Auto-reload on the second configuration.
    do_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_load", cnt1, 16'h0010);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 22; i++) begin
      idle(1);
      en = (i % 10 == 0) ? 10 : 10 - (i % 10);
      chk("t5_cnt", cnt1, to_bcd(en));
      chk("t5_pulse", 16'(done1), 16'(i % 10 == 0));
      chk("t5_run", 16'(run1), 16'd1);
    end

    // Reset mid-run, then simultaneous start and increment.
    idle(3);
    do_reset();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_run", 16'(run0), 16'd1);
    chk("t6_keep", cnt0, 16'h1000);

    // Randomised traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) mu_v = ~mu_v;
      pr = int'($urandom_range(0, 99));
      if (pr == 0) do_reset();
      else if (pr < 22)
        cycle(bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1) == 0),
              bit'($urandom_range(0, 4) == 0), bit'($urandom_range(0, 4) == 0),
              bit'($urandom_range(0, 3) == 0));
      else idle(1);
      if (i % 1000 == 999) idle(150);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
